// File: rtl/psd_digital_core_pkg.sv
// PSD digital core: shared constants, packet layout, link FSM states.
// Holds register-file defaults, packet field positions and the 16x oversample factor.
package psd_digital_core_pkg;

    localparam int DEF_NUMREGS   = 16;
    localparam int DEF_WORDWIDTH = 8;
    localparam int OVERSAMPLE    = 16;
    localparam int PKT_BITS      = 18;

    localparam int WRB_BIT  = 0;
    localparam int DATA_LSB = 1;
    localparam int DATA_MSB = 8;
    localparam int ADDR_LSB = 9;
    localparam int ADDR_MSB = 16;
    localparam int PAR_BIT  = 17;

    localparam logic [7:0] REG_DEF_ZERO  = 8'h00;
    localparam logic [7:0] REG_DEF_OTHER = 8'h80;

    localparam logic [DEF_NUMREGS-1:0][7:0] REG_DEFAULTS =
        {{(DEF_NUMREGS-1){REG_DEF_OTHER}}, REG_DEF_ZERO};

    // Field order matches bit positions above: parity at MSB, wrb at LSB.
    typedef struct packed {
        logic       parity;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wrb;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } link_state_t;

    // Parity bit that makes the whole 18-bit packet hold an odd number of ones.
    function automatic logic odd_parity(input logic [PAR_BIT-1:0] body);
        return ~^body;
    endfunction

endpackage

// File: rtl/psd_digital_core_if.sv
// PSD digital core: serial link bundle (posi command in, piso reply out).
// master = host side, slave = core side.
interface psd_digital_core_if;
    logic posi;
    logic piso;

    modport master (output posi, input piso);
    modport slave  (input  posi, output piso);
endinterface

// File: rtl/psd_uart_link.sv
// PSD UART link: 16x-oversampled RX deframer and TX serializer.
// Ports: clk, reset_n, ser (posi/piso), rx_valid/rx_pkt out, tx_valid/tx_ready/tx_pkt in.
module psd_uart_link
    import psd_digital_core_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    psd_digital_core_if.slave ser,
    output logic              rx_valid,
    output pkt_t              rx_pkt,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  pkt_t              tx_pkt
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_BIT = 5'(PKT_BITS - 1);

    // ---------------- RX ----------------
    logic [2:0]          rx_sync;
    link_state_t         rx_state;
    logic [CW-1:0]       rx_cnt;
    logic [4:0]          rx_idx;
    logic [PKT_BITS-1:0] rx_shift;
    logic                rx_bit;
    logic                rx_fall;

    // rx_sync[1] is the synchronized line; rx_sync[2] its previous value.
    assign rx_bit  = rx_sync[1];
    assign rx_fall = rx_sync[2] & ~rx_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync  <= 3'b111;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_pkt   <= '0;
        end else begin
            rx_sync  <= {rx_sync[1:0], ser.posi};
            rx_valid <= 1'b0;
            unique case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= ST_START;
                        rx_cnt   <= '0;
                    end
                end
                ST_START: begin
                    rx_cnt <= rx_cnt + 1'b1;
                    if (rx_cnt == MID && rx_bit) begin
                        rx_state <= ST_IDLE;
                    end else if (rx_cnt == LAST) begin
                        rx_state <= ST_DATA;
                        rx_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    rx_cnt <= rx_cnt + 1'b1;
                    // LSB arrives first, so shift in from the top.
                    if (rx_cnt == MID) begin
                        rx_shift <= {rx_bit, rx_shift[PKT_BITS-1:1]};
                    end
                    if (rx_cnt == LAST) begin
                        if (rx_idx == LAST_BIT) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    rx_cnt <= rx_cnt + 1'b1;
                    if (rx_cnt == MID) begin
                        rx_state <= ST_IDLE;
                        if (rx_bit) begin
                            rx_valid <= 1'b1;
                            rx_pkt   <= pkt_t'(rx_shift);
                        end
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- TX ----------------
    link_state_t         tx_state;
    logic [CW-1:0]       tx_cnt;
    logic [4:0]          tx_idx;
    logic [PKT_BITS-1:0] tx_shift;
    logic                piso_q;

    assign tx_ready = (tx_state == ST_IDLE);
    assign ser.piso = piso_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            piso_q   <= 1'b1;
        end else begin
            unique case (tx_state)
                ST_IDLE: begin
                    piso_q <= 1'b1;
                    if (tx_valid) begin
                        tx_state <= ST_START;
                        tx_shift <= tx_pkt;
                        tx_cnt   <= '0;
                        piso_q   <= 1'b0;
                    end
                end
                ST_START: begin
                    tx_cnt <= tx_cnt + 1'b1;
                    if (tx_cnt == LAST) begin
                        tx_state <= ST_DATA;
                        tx_idx   <= '0;
                        piso_q   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                ST_DATA: begin
                    tx_cnt <= tx_cnt + 1'b1;
                    if (tx_cnt == LAST) begin
                        if (tx_idx == LAST_BIT) begin
                            tx_state <= ST_STOP;
                            piso_q   <= 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            piso_q   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                ST_STOP: begin
                    tx_cnt <= tx_cnt + 1'b1;
                    piso_q <= 1'b1;
                    if (tx_cnt == LAST) begin
                        tx_state <= ST_IDLE;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/psd_digital_core.sv
// PSD digital core: UART-accessed configuration register file driving the analog core.
// Ports: clk, reset_n, ser (posi/piso), config_bits (register n at [8n+7:8n]). Option: UART_PARITY_CHECK_EN.
module psd_digital_core
    import psd_digital_core_pkg::*;
#(
    parameter int NUMREGS   = DEF_NUMREGS,
    parameter int WORDWIDTH = DEF_WORDWIDTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    psd_digital_core_if.slave              ser,
    output logic [NUMREGS*WORDWIDTH-1:0]   config_bits
);

    localparam int AW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
    localparam logic [NUMREGS-1:0][WORDWIDTH-1:0] RST_IMG =
        {{(NUMREGS-1){WORDWIDTH'(REG_DEF_OTHER)}}, WORDWIDTH'(REG_DEF_ZERO)};

    logic [NUMREGS-1:0][WORDWIDTH-1:0] regs;

    logic    rx_valid;
    pkt_t    rx_pkt;
    logic    tx_ready;
    logic    rep_valid;
    pkt_t    rep_pkt;
    pkt_t    rep_next;
    logic    accept;
    logic    addr_ok;
    logic    do_write;
    logic    par_ok;
    logic [AW-1:0] idx;
    logic [7:0]    rd_data;

    psd_uart_link u_link (
        .clk      (clk),
        .reset_n  (reset_n),
        .ser      (ser),
        .rx_valid (rx_valid),
        .rx_pkt   (rx_pkt),
        .tx_valid (rep_valid),
        .tx_ready (tx_ready),
        .tx_pkt   (rep_pkt)
    );

    assign par_ok  = ^rx_pkt;
    assign addr_ok = ({24'd0, rx_pkt.addr} < NUMREGS);
    assign idx     = rx_pkt.addr[AW-1:0];

`ifdef UART_PARITY_CHECK_EN
    assign accept = rx_valid & par_ok;
`else
    logic par_unused;
    assign par_unused = par_ok;
    assign accept     = rx_valid;
`endif

    assign do_write = accept & ~rx_pkt.wrb & addr_ok;

    // Reply carries post-write contents; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (addr_ok) begin
            rd_data = rx_pkt.wrb ? 8'(regs[idx]) : rx_pkt.data;
        end
    end

    always_comb begin
        rep_next        = '0;
        rep_next.wrb    = rx_pkt.wrb;
        rep_next.addr   = rx_pkt.addr;
        rep_next.data   = rd_data;
        rep_next.parity = odd_parity({rx_pkt.addr, rd_data, rx_pkt.wrb});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= RST_IMG;
        end else if (do_write) begin
            regs[idx] <= WORDWIDTH'(rx_pkt.data);
        end
    end

    // Single reply slot: new replies are dropped while it is occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_valid <= 1'b0;
            rep_pkt   <= '0;
        end else if (accept && !rep_valid) begin
            rep_valid <= 1'b1;
            rep_pkt   <= rep_next;
        end else if (rep_valid && tx_ready) begin
            rep_valid <= 1'b0;
        end
    end

    assign config_bits = regs;

endmodule

// File: tb/tb_psd_digital_core.sv
// PSD digital core bench: directed UART packets with queued expected replies.
// A monitor deserializes piso and compares each reply against the queue head.
module tb_psd_digital_core;

    localparam int NREG = 16;

    logic clk;
    logic reset_n;
    logic [NREG*8-1:0] config_bits;

    psd_digital_core_if bus ();

    psd_digital_core dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ser         (bus),
        .config_bits (config_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_rx = 0;
    logic [17:0] exp_q[$];
    logic [7:0] mdl [NREG];

    function automatic logic [17:0] mk_word(input logic wrb,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
        logic [17:0] w;
        w = {1'b0, addr, data, wrb};
        w[17] = ($countones(w[16:0]) % 2 == 0);
        return w;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NREG; i++) mdl[i] = (i == 0) ? 8'h00 : 8'h80;
    endtask

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_cfg(input string name);
        logic [NREG*8-1:0] want;
        for (int i = 0; i < NREG; i++) want[i*8 +: 8] = mdl[i];
        check(name, 128'(config_bits), 128'(want));
    endtask

    // mode: 0 = no reply expected, 1 = reply from model, 2 = explicit reply
    task automatic send(input logic wrb, input logic [7:0] addr,
                        input logic [7:0] data, input logic flip,
                        input int mode, input logic [17:0] exp_word);
        logic [17:0] p;
        logic [7:0]  rd;
        p = mk_word(wrb, addr, data);
        if (flip) p[17] = ~p[17];
        if (mode != 0) begin
            if (addr < NREG) begin
                if (!wrb) mdl[addr[3:0]] = data;
                rd = mdl[addr[3:0]];
            end else begin
                rd = 8'h00;
            end
            exp_q.push_back(mode == 2 ? exp_word : mk_word(wrb, addr, rd));
        end
        bus.posi = 1'b0;
        repeat (16) @(negedge clk);
        for (int b = 0; b < 18; b++) begin
            bus.posi = p[b];
            repeat (16) @(negedge clk);
        end
        bus.posi = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
        repeat (24) @(negedge clk);
    endtask

    initial begin : monitor
        logic [17:0] got;
        logic [17:0] want;
        logic st;
        logic sp;
        forever begin
            @(negedge bus.piso);
            repeat (8) @(negedge clk);
            st = bus.piso;
            for (int b = 0; b < 18; b++) begin
                repeat (16) @(negedge clk);
                got[b] = bus.piso;
            end
            repeat (16) @(negedge clk);
            sp = bus.piso;
            n_rx++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_reply got=%h", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want || st !== 1'b0 || sp !== 1'b1) begin
                    bad++;
                    $display("FAIL reply got=%h start=%b stop=%b want=%h",
                             got, st, sp, want);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n0;
        logic [NREG*8-1:0] snap;
        bus.posi = 1'b1;
        reset_n  = 1'b0;
        mdl_reset();
        repeat (5) @(negedge clk);
        check("reset_piso", 128'(bus.piso), 128'd1);
        check("reset_cfg", 128'(config_bits),
              {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
               8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00});
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        send(1'b1, 8'h00, 8'h5A, 1'b0, 2, 18'h00001);
        send(1'b1, 8'h05, 8'h00, 1'b0, 2, 18'h20B01);

        send(1'b0, 8'h03, 8'hA5, 1'b0, 2, 18'h2074A);
        check("cfg_reg3", 128'(config_bits[31:24]), 128'hA5);
        send(1'b1, 8'h03, 8'h00, 1'b0, 2, 18'h0074B);
        drain("drain_basic");
        check_cfg("cfg_after_write");

        snap = config_bits;
        send(1'b0, 8'h20, 8'h11, 1'b0, 2, 18'h04000);
        drain("drain_oob");
        check("cfg_oob_unchanged", 128'(config_bits), 128'(snap));

        n0 = n_rx;
        bus.posi = 1'b0;
        #15;
        bus.posi = 1'b1;
        repeat (400) @(negedge clk);
        check("runt_no_reply", 128'(n_rx), 128'(n0));
        send(1'b1, 8'h03, 8'h00, 1'b0, 1, 18'h0);
        drain("drain_after_runt");

        n0 = n_rx;
`ifdef UART_PARITY_CHECK_EN
        send(1'b0, 8'h01, 8'h3C, 1'b1, 0, 18'h0);
        repeat (400) @(negedge clk);
        check("badpar_no_reply", 128'(n_rx), 128'(n0));
        check("badpar_reg1", 128'(config_bits[15:8]), 128'h80);
`else
        send(1'b0, 8'h01, 8'h3C, 1'b1, 1, 18'h0);
        drain("drain_badpar");
        check("badpar_count", 128'(n_rx), 128'(n0 + 1));
        check("badpar_reg1", 128'(config_bits[15:8]), 128'h3C);
`endif

        bus.posi = 1'b0;
        repeat (16) @(negedge clk);
        bus.posi = 1'b1;
        repeat (40) @(negedge clk);
        bus.posi = 1'b0;
        repeat (20) @(negedge clk);
        reset_n  = 1'b0;
        bus.posi = 1'b1;
        mdl_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_cfg("cfg_midframe_reset");
        send(1'b1, 8'h05, 8'h00, 1'b0, 2, 18'h20B01);
        drain("drain_after_reset");

        for (int i = 0; i < 110; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)),
                 8'($urandom), 1'b0, 1, 18'h0);
            if (i % 22 == 21) check_cfg("cfg_random");
        end
        drain("drain_random");
        check_cfg("cfg_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
